// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master data RAM arbiter with bounded master 1 lock.
// Define RAM_ARB_RR_EN for round-robin contention in ARB; otherwise master 0 has fixed priority.
module ram_arbiter #(
    parameter int AW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [3:0]    m0_wen,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_wen,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [31:0]   ram_w_data,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [31:0]   ram_r_data
);
    typedef enum logic {ARB, LOCK1} state_t;
    state_t state, state_nx;
    logic [7:0] starve_cnt, starve_nx;
    logic [1:0] rtag;
    logic force_m0, m0_wins, any_gnt;
    logic [3:0] sel_wen;
    logic [AW-1:0] sel_addr;
`ifdef RAM_ARB_RR_EN
    logic last_m1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_m1 <= 1'b1;
        else if (any_gnt) last_m1 <= m1_gnt;
    end
    assign m0_wins = last_m1;
`else
    assign m0_wins = 1'b1;
`endif
    always_comb begin
        force_m0   = state == LOCK1 && m0_req && starve_cnt == 8'(LOCK_MAX);
        m0_gnt     = state == ARB ? m0_req && (!m1_req || m0_wins) : force_m0;
        m1_gnt     = m1_req && !m0_gnt;
        any_gnt    = m0_gnt || m1_gnt;
        sel_wen    = m1_gnt ? m1_wen : m0_wen;
        sel_addr   = m1_gnt ? m1_addr : m0_addr;
        ram_wen    = any_gnt ? sel_wen : 4'd0;
        ram_ren    = any_gnt && sel_wen == 4'd0;
        ram_w_addr = sel_addr;
        ram_r_addr = sel_addr;
        ram_w_data = m1_gnt ? m1_wdata : m0_wdata;
        state_nx   = state == ARB ? ((m1_gnt && m1_lock) ? LOCK1 : ARB) : (m1_lock ? LOCK1 : ARB);
        // In LOCK1 a requesting master 0 that is not forced through is always denied
        starve_nx  = (state == ARB || !m1_lock || force_m0) ? 8'd0 : starve_cnt + {7'd0, m0_req};
        m0_rvalid  = rtag[0];
        m1_rvalid  = rtag[1];
        m0_rdata   = rtag[0] ? ram_r_data : 32'd0;
        m1_rdata   = rtag[1] ? ram_r_data : 32'd0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            starve_cnt <= 8'd0;
            rtag       <= 2'b00;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            rtag       <= {m1_gnt && m1_wen == 4'd0, m0_gnt && m0_wen == 4'd0};
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/RAM model.
module tb_ram_arbiter;
    localparam int LM = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [3:0] m0_wen = 4'd0, m1_wen = 4'd0;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0, m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren;
    logic [31:0] m0_rdata, m1_rdata, ram_w_addr, ram_w_data, ram_r_addr;
    logic [3:0] ram_wen;
    logic [31:0] ram_r_data = 32'd0;
    logic [31:0] mem [16] = '{default: 32'd0};
    logic [31:0] exp_mem [16] = '{default: 32'd0};
    int checks = 0, failures = 0;
    ram_arbiter #(.AW(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ram_ren) ram_r_data <= mem[ram_r_addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_w_addr[5:2]][8*b +: 8] <= ram_w_data[8*b +: 8];
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_wen = 4'd0; m1_wen = 4'd0;
    endtask
    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask
    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren, ram_wen, m0_rdata, m1_rdata} !== 72'd0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b ren=%b wen=%h rd0=%h rd1=%h want all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren, ram_wen, m0_rdata, m1_rdata);
        end
        rst = 1'b1;
        tick();
    endtask
    task automatic test_read();
        m0_req = 1'b1; m0_wen = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        exp_mem[4] = 32'hDEADBEEF;
        tick();
        m0_wen = 4'd0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, ram_ren, ram_wen, ram_r_addr} !== {1'b1, 1'b1, 4'd0, 32'h10}) begin
            failures++;
            $display("FAIL read_issue got gnt=%b ren=%b wen=%h raddr=%h want 1 1 0 00000010",
                     m0_gnt, ram_ren, ram_wen, ram_r_addr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_rdata, m1_rvalid, m1_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL read_data got rv0=%b rd0=%h rv1=%b rd1=%h want 1 deadbeef 0 0",
                     m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
        end
        tick();
    endtask
    task automatic test_write();
        m1_req = 1'b1; m1_wen = 4'b0010; m1_addr = 32'h20; m1_wdata = 32'h0000AB00;
        exp_mem[8][15:8] = 8'hAB;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt, ram_wen, ram_w_addr, ram_w_data, ram_ren} !==
            {1'b1, 1'b0, 4'b0010, 32'h20, 32'h0000AB00, 1'b0}) begin
            failures++;
            $display("FAIL write_issue got gnt1=%b gnt0=%b wen=%b waddr=%h wdata=%h ren=%b want 1 0 0010 20 0000ab00 0",
                     m1_gnt, m0_gnt, ram_wen, ram_w_addr, ram_w_data, ram_ren);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL write_no_rvalid got rv0=%b rv1=%b want 0 0", m0_rvalid, m1_rvalid);
        end
        tick();
    endtask
    task automatic test_back_to_back();
        logic e0, prev0;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h20;
        prev0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle();
`ifdef RAM_ARB_RR_EN
            e0 = (i % 2) == 0;
`else
            e0 = 1'b1;
`endif
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if ({m0_gnt, m1_gnt} !== {e0, !e0}) begin
                    failures++;
                    $display("FAIL contention cycle %0d got gnt=%b%b want %b%b", i, m0_gnt, m1_gnt, e0, !e0);
                end
            end
            if (i > 0) begin
                checks++;
                if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
                    {prev0, !prev0, prev0 ? exp_mem[4] : 32'd0, prev0 ? 32'd0 : exp_mem[8]}) begin
                    failures++;
                    $display("FAIL b2b_return cycle %0d got rv=%b%b rd0=%h rd1=%h want src m%0d",
                             i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, prev0 ? 0 : 1);
                end
            end
            prev0 = e0;
            tick();
        end
    endtask
    task automatic test_lock();
        logic e0;
        do_reset();
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1) begin
            failures++;
            $display("FAIL lock_start got gnt1=%b want 1", m1_gnt);
        end
        tick();
        m0_req = 1'b1; m0_addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            m1_lock = i < 5;
`ifdef RAM_ARB_RR_EN
            e0 = i == 4 || i == 6;
`else
            e0 = i == 4 || i >= 6;
`endif
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== {e0, !e0}) begin
                failures++;
                $display("FAIL lock_seq cycle %0d got gnt=%b%b want %b%b", i, m0_gnt, m1_gnt, e0, !e0);
            end
            tick();
        end
        idle();
    endtask
    task automatic test_reset_inflight();
        do_reset();
        m0_req = 1'b1; m0_wen = 4'd0; m0_addr = 32'h10;
        #2;
        checks++;
        if ({m0_gnt, ram_ren} !== 2'b11) begin
            failures++;
            $display("FAIL inflight_issue got gnt=%b ren=%b want 1 1", m0_gnt, ram_ren);
        end
        rst = 1'b0;
        m0_req = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren, ram_wen, m0_rdata, m1_rdata} !== 72'd0) begin
            failures++;
            $display("FAIL inflight_reset_outputs got gnt=%b%b rv=%b%b ren=%b wen=%h want all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren, ram_wen);
        end
        rst = 1'b1;
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_rdata, m0_gnt, m1_gnt} !== {1'b0, 32'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL inflight_discard got rv0=%b rd0=%h gnt=%b%b want 0 0 10",
                     m0_rvalid, m0_rdata, m0_gnt, m1_gnt);
        end
        tick();
        idle();
    endtask
    task automatic test_random();
        logic lk, last1, p0, p1, e0, e1, frc, act;
        logic [3:0] ew;
        logic [31:0] ea, pd;
        int sc;
        do_reset();
        lk = 1'b0; last1 = 1'b1; sc = 0; p0 = 1'b0; p1 = 1'b0; pd = 32'd0;
        for (int n = 0; n < 400; n++) begin
            m0_req = $urandom_range(0, 3) != 0;
            m1_req = $urandom_range(0, 3) != 0;
            m1_lock = $urandom_range(0, 9) < 7;
            m0_wen = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            m1_wen = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            m0_addr = 32'($urandom_range(0, 15)) << 2;
            m1_addr = 32'($urandom_range(0, 15)) << 2;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            if (lk) begin
                frc = m0_req && sc == LM;
                e0 = frc;
            end else begin
                frc = 1'b0;
`ifdef RAM_ARB_RR_EN
                e0 = m0_req && (!m1_req || last1);
`else
                e0 = m0_req;
`endif
            end
            e1 = m1_req && !e0;
            act = e0 || e1;
            ew = e1 ? m1_wen : m0_wen;
            ea = e1 ? m1_addr : m0_addr;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, ram_wen, ram_ren} !== {e0, e1, act ? ew : 4'd0, act && ew == 4'd0}) begin
                failures++;
                $display("FAIL rand_grant n=%0d got gnt=%b%b wen=%h ren=%b want %b%b %h %b",
                         n, m0_gnt, m1_gnt, ram_wen, ram_ren, e0, e1, act ? ew : 4'd0, act && ew == 4'd0);
            end
            if (act) begin
                checks++;
                if ((ew == 4'd0 && ram_r_addr !== ea) ||
                    (ew != 4'd0 && {ram_w_addr, ram_w_data} !== {ea, e1 ? m1_wdata : m0_wdata})) begin
                    failures++;
                    $display("FAIL rand_bus n=%0d got raddr=%h waddr=%h wdata=%h want addr %h",
                             n, ram_r_addr, ram_w_addr, ram_w_data, ea);
                end
            end
            checks++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {p0, p1, p0 ? pd : 32'd0, p1 ? pd : 32'd0}) begin
                failures++;
                $display("FAIL rand_rdata n=%0d got rv=%b%b rd0=%h rd1=%h want rv=%b%b data %h",
                         n, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, p0, p1, pd);
            end
            p0 = e0 && ew == 4'd0;
            p1 = e1 && ew == 4'd0;
            if (act && ew == 4'd0) pd = exp_mem[ea[5:2]];
            if (act)
                for (int b = 0; b < 4; b++)
                    if (ew[b]) exp_mem[ea[5:2]][8*b +: 8] = (e1 ? m1_wdata : m0_wdata) >> (8 * b);
            if (act) last1 = e1;
            if (lk) begin
                if (!m1_lock || frc) sc = 0;
                else if (m0_req) sc++;
                lk = m1_lock;
            end else begin
                lk = e1 && m1_lock;
            end
            tick();
        end
        idle();
    endtask
    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_lock();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
